// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion with an 11-entry round key file
// One round key per cycle after start; any round key readable combinationally once ready.
module aes_key_schedule #(
  parameter int NROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         start,
  output logic         busy,
  output logic         ready,
  input  logic [3:0]   rd_index,
  output logic [127:0] rd_key
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  state_t       state, state_next;
  logic [3:0]   counter;
  logic [127:0] slots [0:NROUNDS];
  logic [127:0] prev_key, next_key;
  logic [31:0]  t_word, w0n, w1n, w2n, w3n;
  logic [7:0]   rcon;
  logic         load;

  // start is ignored mid-expansion so the latched key runs to completion
  assign load = start && (state != S_EXPAND);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_EXPAND;
      S_EXPAND: if (counter == LAST) state_next = S_READY;
      S_READY:  if (start) state_next = S_EXPAND;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_EXPAND);
    ready = (state == S_READY);
  end

  always_comb begin
    case (counter)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // SubWord(RotWord(w3)): rotate left one byte, then substitute each byte
  always_comb begin
    prev_key = slots[counter - 4'd1];
    t_word   = {SBOX[prev_key[23:16]], SBOX[prev_key[15:8]],
                SBOX[prev_key[7:0]],   SBOX[prev_key[31:24]]} ^ {rcon, 24'h000000};
    w0n      = prev_key[127:96] ^ t_word;
    w1n      = prev_key[95:64]  ^ w0n;
    w2n      = prev_key[63:32]  ^ w1n;
    w3n      = prev_key[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter <= 4'd0;
      for (int i = 0; i <= NROUNDS; i++) slots[i] <= '0;
    end else if (load) begin
      slots[0] <= key;
      counter  <= 4'd1;
    end else if (state == S_EXPAND) begin
      slots[counter] <= next_key;
      counter        <= (counter == LAST) ? 4'd0 : counter + 4'd1;
    end
  end

  assign rd_key = (ready && rd_index <= LAST) ? slots[rd_index] : '0;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule
// Reference expansion derives the S-box from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

  typedef logic [0:10][127:0] rk_t;
  typedef struct {
    rk_t keys;
    int  start_edge;
  } entry_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic         start;
  logic         busy;
  logic         ready;
  logic [3:0]   rd_index;
  logic [127:0] rd_key;

  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  entry_t sb[$];
  logic [7:0] sbt [256];

  aes_key_schedule #(.NROUNDS(10)) dut (
    .clock(clock), .reset_n(reset_n), .key(key), .start(start),
    .busy(busy), .ready(ready), .rd_index(rd_index), .rd_key(rd_key)
  );

  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_of(input logic [7:0] a);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    r = inv; s = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic rk_t expand_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rk_t         rk;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Stimulus side: drive start for one edge, push the expected round keys
  task automatic issue(input logic [127:0] k, input rk_t exp, input int pulse_at, input logic [127:0] other);
    entry_t e;
    key = k;
    start = 1'b1;
    e.keys = exp;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    key = ~k;
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) @(negedge clock);
      key = other;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      key = ~other;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: %0d expansions pending after %0d cycles, required 0", sb.size(), n);
      sb.delete();
    end
    @(negedge clock);
  endtask

  // Monitor: pops an entry whenever ready rises and sweeps the read port
  initial begin
    logic   prev_rdy;
    entry_t e;
    logic [127:0] exp;
    prev_rdy = 1'b0;
    rd_index = 4'd0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        prev_rdy = 1'b0;
        continue;
      end
      check("busy_ready_exclusive", {127'b0, busy & ready}, 128'd0);
      if (!ready) check("rd_key_gated", rd_key, 128'd0);
      if (ready && !prev_rdy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected no pending expansion", cyc);
        end else begin
          e = sb.pop_front();
          check("latency", 128'(cyc - e.start_edge), 128'd10);
          for (int i = 0; i < 16; i++) begin
            rd_index = 4'(i);
            #1;
            exp = (i <= 10) ? e.keys[i] : 128'd0;
            check($sformatf("rd_key[%0d]", i), rd_key, exp);
          end
        end
      end
      prev_rdy = ready;
      rd_index = 4'($urandom_range(0, 15));
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rk_t rk, rk_fips, rk_zero;
    logic [127:0] k;
    int c0;
    reset_n = 1'b0;
    start   = 1'b0;
    key     = '0;
    for (int i = 0; i < 256; i++) sbt[i] = sbox_of(8'(i));

    repeat (2) @(negedge clock);
    check("reset_busy",   {127'b0, busy},  128'd0);
    check("reset_ready",  {127'b0, ready}, 128'd0);
    check("reset_rd_key", rd_key,          128'd0);
    reset_n = 1'b1;
    @(negedge clock);

    rk_fips = expand_ref(FIPS_KEY);
    rk_fips[0]  = FIPS_KEY;
    rk_fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    issue(FIPS_KEY, rk_fips, 0, '0);
    wait_done();

    rk_zero = expand_ref(128'd0);
    rk_zero[1]  = 128'h62636363626363636263636362636363;
    rk_zero[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    issue(128'd0, rk_zero, 0, '0);
    wait_done();

    rk = expand_ref(SEQ_KEY);
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    issue(SEQ_KEY, rk, 0, '0);
    wait_done();

    issue(FIPS_KEY, rk_fips, 4, 128'd0);
    wait_done();

    k = {$urandom, $urandom, $urandom, $urandom};
    rk = expand_ref(k);
    key = k;
    start = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 3; j++) begin
      entry_t e;
      e.keys = rk;
      e.start_edge = c0 + 1 + 11*j;
      sb.push_back(e);
    end
    repeat (23) @(negedge clock);
    start = 1'b0;
    wait_done();

    k = {$urandom, $urandom, $urandom, $urandom};
    issue(k, expand_ref(k), 0, '0);
    repeat (4) @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midreset_busy",   {127'b0, busy},  128'd0);
    check("midreset_ready",  {127'b0, ready}, 128'd0);
    check("midreset_rd_key", rd_key,          128'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("post_reset_idle_ready", {127'b0, ready}, 128'd0);
      check("post_reset_idle_busy",  {127'b0, busy},  128'd0);
    end

    for (int n = 0; n < 10; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        issue(k, expand_ref(k), int'($urandom_range(1, 9)), {$urandom, $urandom, $urandom, $urandom});
      else
        issue(k, expand_ref(k), 0, '0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion unit that sits directly upstream of the inverse cipher round datapath.
- Takes a 128-bit cipher key and computes round keys 0..10 at one round key per cycle, storing them in an internal 11-entry register file.
- Serves any round key through a combinational read port, so the inverse cipher can index rounds 10 down to 0 without instantiating 11 parallel expanders.
- Contains its own forward S-box (SubWord) and Rcon generation.

Parameters:
- NROUNDS, 10, number of expansion rounds (AES-128 only; other values unsupported).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- key  input  128  cipher key; w0 = key[127:96], w3 = key[31:0].
- start  input  1  request expansion of key; sampled on posedge.
- busy  output  1  high while expansion is in progress.
- ready  output  1  high when all 11 round keys are valid.
- rd_index  input  4  round key index 0..10 to read.
- rd_key  output  128  round key rd_index; {w[4i], w[4i+1], w[4i+2], w[4i+3]}, with w[4i] in [127:96].

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, round counter=0, all 11 slots=0.
  - busy=0, ready=0, rd_key=0.
- States:
  - IDLE: busy=0, ready=0. start=1 -> write key into slot0, counter=1, go to EXPAND.
  - EXPAND: busy=1, ready=0.
    - Each edge computes slot[counter] from slot[counter-1]:
      - t = SubWord(RotWord(w3)) ^ {Rcon[counter],24'h0}
      - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
    - Writes slot[counter], then counter+1.
    - The edge that writes slot10 moves to READY and clears counter to 0.
  - READY: busy=0, ready=1.
    - start=1 -> restart exactly as from IDLE: slot0 = new key, go to EXPAND, ready drops on that edge.
- Rcon for counter 1..10: 01,02,04,08,10,20,40,80,1b,36. Counter 0 or 11..15 never used for expansion.
- RotWord: {b1,b2,b3,b0} of {b0,b1,b2,b3}, b0 = MS byte. SubWord applies the forward AES S-box bytewise.
- Latency:
  - start sampled at edge E0; slots 1..10 written at E1..E10.
  - busy high after E0 through E10; ready high after E10.
  - Fixed 10 cycles from start edge to ready.
- start while in EXPAND: ignored; expansion continues with the originally latched key. key is only sampled on the start edge; changes to key at any other time have no effect.
- Read port:
  - rd_key = slot[rd_index] when ready=1 and rd_index<=10.
  - rd_key = 0 when ready=0 or rd_index>=11.
  - Purely combinational, zero-cycle latency.
- Reset asserted mid-EXPAND: immediate return to IDLE with all slots cleared. After release, no expansion until a new start.
- start held high continuously: re-expands on every IDLE/READY entry. ready pulses high for exactly one cycle between expansions (READY state lasts one cycle since start is sampled there).
- Widths: all XOR on 32-bit words; counter is 4 bits; no overflow, since counter is bounded by the slot10 transition.

Test Plan:
- Reset behaviour:
  - Assert reset_n=0 mid-EXPAND -> busy=0, ready=0, rd_key=0 immediately.
  - After release with start=0 for 20 cycles -> ready stays 0.
- FIPS-197 key:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - ready exactly 10 cycles after start edge.
  - rd_index=0 -> rd_key=2b7e151628aed2a6abf7158809cf4f3c.
  - rd_index=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_index=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Zero key:
  - rd_index=1 -> 62636363626363636263636362636363.
  - rd_index=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Key 000102030405060708090a0b0c0d0e0f:
  - rd_index=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
  - rd_index=11 and rd_index=15 -> 0.
- Start ignored while busy:
  - Start with the FIPS key, pulse start with the zero key at cycle 4.
  - Slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6; ready still at cycle 10.
- Restart from READY:
  - After the FIPS-key expansion completes, start with the zero key.
  - ready=0 and rd_key=0 during EXPAND.
  - ready again 10 cycles later with slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
